// File: rtl/keypad_emulator.sv
// keypad_emulator: passive 4x4 matrix keypad model driven by a column scanner.
// Ports: i_Clk/i_Rst_L clock and sync active-low reset; i_Key_DV/i_Key/o_Key_Ready
// key request handshake; i_Col column drive (active-low); o_Row row sense
// (active-low, idle high); o_Busy press in progress; o_Contact switch state;
// o_Active_Key code of the key being pressed.
module keypad_emulator #(
   parameter int CLKS_PER_PRESS = 250000,
   parameter int CLKS_PER_GAP   = 250000,
   parameter int BOUNCE_CLKS    = 5000,
   parameter int BOUNCE_TOGGLES = 4
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Key_DV,
   input  logic [3:0] i_Key,
   output logic       o_Key_Ready,
   input  logic [3:0] i_Col,
   output logic [3:0] o_Row,
   output logic       o_Busy,
   output logic       o_Contact,
   output logic [3:0] o_Active_Key
);

   localparam int MAX_PG = (CLKS_PER_PRESS > CLKS_PER_GAP) ?
                           CLKS_PER_PRESS : CLKS_PER_GAP;
   localparam int MAXC = (MAX_PG > BOUNCE_CLKS) ? MAX_PG : BOUNCE_CLKS;
   localparam int CW = $clog2(MAXC + 1);
   // A zero toggle count still needs a 1-bit register to stay legal.
   localparam int TW = (BOUNCE_TOGGLES > 0) ?
                       $clog2(BOUNCE_TOGGLES + 1) : 1;

   localparam logic [CW-1:0] PRESS_END  = CW'(CLKS_PER_PRESS - 1);
   localparam logic [CW-1:0] GAP_END    = CW'(CLKS_PER_GAP - 1);
   localparam logic [CW-1:0] BOUNCE_END = CW'(BOUNCE_CLKS - 1);
   localparam logic [TW-1:0] TOG_END    = TW'(BOUNCE_TOGGLES);
   localparam bit NO_BOUNCE = (BOUNCE_TOGGLES == 0);

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_BOUNCE_IN  = 3'd1;
   localparam logic [2:0] ST_HOLD       = 3'd2;
   localparam logic [2:0] ST_BOUNCE_OUT = 3'd3;
   localparam logic [2:0] ST_GAP        = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tog_q, tog_d;
   logic          contact_q, contact_d;
   logic [3:0]    key_q, key_d;
   logic [1:0]    key_row, key_col;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      tog_d     = tog_q;
      contact_d = contact_q;
      key_d     = key_q;
      unique case (state_q)
         ST_IDLE: begin
            contact_d = 1'b0;
            cnt_d     = '0;
            tog_d     = '0;
            if (i_Key_DV) begin
               key_d     = i_Key;
               contact_d = 1'b1;
               state_d   = NO_BOUNCE ? ST_HOLD : ST_BOUNCE_IN;
            end
         end
         ST_BOUNCE_IN, ST_BOUNCE_OUT: begin
            if (cnt_q == BOUNCE_END) begin
               cnt_d = '0;
               if (tog_q == TOG_END) begin
                  // Final interval done: settle into the stable state.
                  tog_d = '0;
                  if (state_q == ST_BOUNCE_IN) begin
                     state_d   = ST_HOLD;
                     contact_d = 1'b1;
                  end else begin
                     state_d   = ST_GAP;
                     contact_d = 1'b0;
                  end
               end else begin
                  tog_d     = tog_q + 1'b1;
                  contact_d = ~contact_q;
               end
            end
         end
         ST_HOLD: begin
            contact_d = 1'b1;
            if (cnt_q == PRESS_END) begin
               cnt_d     = '0;
               contact_d = 1'b0;
               state_d   = NO_BOUNCE ? ST_GAP : ST_BOUNCE_OUT;
            end
         end
         ST_GAP: begin
            contact_d = 1'b0;
            if (cnt_q == GAP_END) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            contact_d = 1'b0;
            cnt_d     = '0;
            tog_d     = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         tog_q     <= '0;
         contact_q <= 1'b0;
         key_q     <= 4'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tog_q     <= tog_d;
         contact_q <= contact_d;
         key_q     <= key_d;
      end
   end

   // Keypad layout: {row, col} of each key code.
   always_comb begin
      {key_row, key_col} = 4'b0000;
      unique case (key_q)
         4'h1: {key_row, key_col} = 4'b0000;
         4'h2: {key_row, key_col} = 4'b0001;
         4'h3: {key_row, key_col} = 4'b0010;
         4'hA: {key_row, key_col} = 4'b0011;
         4'h4: {key_row, key_col} = 4'b0100;
         4'h5: {key_row, key_col} = 4'b0101;
         4'h6: {key_row, key_col} = 4'b0110;
         4'hB: {key_row, key_col} = 4'b0111;
         4'h7: {key_row, key_col} = 4'b1000;
         4'h8: {key_row, key_col} = 4'b1001;
         4'h9: {key_row, key_col} = 4'b1010;
         4'hC: {key_row, key_col} = 4'b1011;
         4'hE: {key_row, key_col} = 4'b1100;
         4'h0: {key_row, key_col} = 4'b1101;
         4'hF: {key_row, key_col} = 4'b1110;
         4'hD: {key_row, key_col} = 4'b1111;
         default: {key_row, key_col} = 4'b0000;
      endcase
   end

   // A closed switch simply shorts its column line onto its row line.
   always_comb begin
      o_Row = 4'hF;
      if (contact_q) o_Row[key_row] = i_Col[key_col];
   end

   assign o_Key_Ready  = (state_q == ST_IDLE);
   assign o_Busy       = (state_q != ST_IDLE);
   assign o_Contact    = contact_q;
   assign o_Active_Key = key_q;

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Behavioural emulator of a 4x4 matrix keypad; the passive switch end of the column-scan/row-sense interface that the keypad decoder drives.
- Accepts key codes over a valid/ready handshake and "presses" each key for a programmable time.
- During each press it optionally generates contact bounce, then holds a release gap.
- Presents rows exactly as a physical keypad would. Used in benches and on-board self-test in place of the PMOD keypad.

Parameters:
- CLKS_PER_PRESS, 250000, stable-closed hold duration in clocks (>=1)
- CLKS_PER_GAP, 250000, stable-open release gap after each press in clocks (>=1)
- BOUNCE_CLKS, 5000, clocks between contact toggles during bounce (>=1)
- BOUNCE_TOGGLES, 4, contact toggles at press and at release (0 = no bounce)

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  reset; synchronous, active-low
- i_Key_DV  in  1  key request valid
- i_Key  in  4  requested key code (hex 0-F)
- o_Key_Ready  out  1  emulator can accept a request
- i_Col  in  4  column drive from scanner, active-low; i_Col[c] = column c
- o_Row  out  4  row sense to scanner, active-low, idle high; o_Row[r] = row r
- o_Busy  out  1  press sequence in progress
- o_Contact  out  1  current switch contact state (1 = closed)
- o_Active_Key  out  4  latched code of key being pressed

Behaviour:
- Key map, fixed (row r: columns 0..3):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D (E = '*', F = '#')
  - Latched code is converted to (key_row, key_col) via this table.
- Row output is combinational from i_Col, which models a bare switch:
  - o_Row[key_row] = i_Col[key_col] when o_Contact = 1.
  - All other o_Row bits are 1.
  - With contact open, o_Row = 4'hF.
  - Zero-cycle path; no registering.
- Handshake:
  - o_Key_Ready = 1 only in IDLE.
  - Transfer occurs on a rising edge where i_Key_DV & o_Key_Ready.
  - i_Key is latched into o_Active_Key on that edge.
  - Requests while not ready are ignored; no queueing.
  - i_Key_DV does not need to drop between requests.
- FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
  - IDLE: contact open, o_Busy = 0. On transfer go to BOUNCE_IN, or to HOLD if BOUNCE_TOGGLES = 0.
  - BOUNCE_IN: contact closed on entry. Contact inverts every BOUNCE_CLKS clocks. After BOUNCE_TOGGLES toggles plus a final BOUNCE_CLKS interval, go to HOLD.
  - HOLD: contact forced closed for exactly CLKS_PER_PRESS clocks, then go to BOUNCE_OUT, or to GAP if BOUNCE_TOGGLES = 0.
  - BOUNCE_OUT: contact open on entry. Toggles as in BOUNCE_IN, then go to GAP.
  - GAP: contact forced open for exactly CLKS_PER_GAP clocks, then go to IDLE.
- Timing:
  - Contact first closes in the cycle after the transfer edge.
  - With BOUNCE_TOGGLES = 0: contact is closed for exactly CLKS_PER_PRESS cycles, then open.
  - o_Key_Ready rises exactly CLKS_PER_GAP cycles after contact opens.
  - o_Busy = 1 in every non-IDLE state.
- Counters:
  - One duration counter, width $clog2 of max(CLKS_PER_PRESS, CLKS_PER_GAP, BOUNCE_CLKS)+1.
  - One toggle counter, width $clog2(BOUNCE_TOGGLES+1).
  - Both clear on every state entry; no wrap is possible.
- o_Active_Key holds its value through GAP and until the next transfer.
- Reset (i_Rst_L = 0 at an edge):
  - state IDLE, o_Contact = 0, o_Busy = 0, o_Active_Key = 0, counters 0.
  - o_Key_Ready = 1 from the cycle after reset deasserts.
  - o_Row = 4'hF.
  - Reset mid-press aborts immediately. No GAP is inserted.
- Simultaneous events:
  - A transfer and a column change on the same edge are independent; rows follow i_Col combinationally.
  - Multiple low i_Col bits are allowed: only key_col matters.

Test Plan:
- Params PRESS=8, GAP=4, TOGGLES=0: send key 5 (row1, col1); drive i_Col=4'b1101 -> o_Row=4'b1101 for exactly 8 cycles starting the cycle after transfer. Drive i_Col=4'b1110 -> o_Row=4'hF throughout. Then o_Key_Ready rises 4 cycles after release.
- Map sweep: all 16 codes, each while scanning i_Col one-hot-low -> the low o_Row bit appears only for the tabled row/col (e.g. 0 -> row3/col1, D -> row3/col3, A -> row0/col3).
- Bounce, TOGGLES=3, BOUNCE_CLKS=2: send key 1 with i_Col=4'b1110 -> o_Contact pattern 1,1,0,0,1,1,0,0 then closed for 8. On release: 0,0,1,1,0,0,1,1 then open for 4.
- Back-to-back requests with i_Key_DV held high, keys 3 then 9 -> second transfer occurs exactly on the first IDLE cycle. Requests during Busy are ignored (o_Active_Key unchanged).
- Assert i_Rst_L=0 mid-HOLD -> next cycle o_Row=4'hF, o_Busy=0, o_Active_Key=0. o_Key_Ready=1 the cycle after release, with no gap.
- Loop with the keypad decoder: emulate keys 0-F in turn -> decoder output equals each code after its debounce.
